// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle instruction fetch stage.
// Owns the PC, reads a 1-cycle-latency instruction SRAM, and holds
// {pc, inst} for the consumer until a valid/ready handshake completes.
// Redirects restart fetch from any state.
// Optional build macro FETCH_ADEF_EN: misaligned PCs skip the SRAM access
// and are presented with inst=0 and fetch_adef=1.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
`ifdef FETCH_ADEF_EN
  output logic        fetch_adef,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_RESP = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        out_valid_q, out_valid_d;
  logic        adef_q, adef_d;
  logic        misal_c;

  // Alignment fault detection for the current fetch address
`ifdef FETCH_ADEF_EN
  assign misal_c    = (pc_q[1:0] != 2'b00);
  assign fetch_adef = adef_q;
`else
  assign misal_c    = 1'b0;
`endif

  // SRAM request strobe is a state decode, forced low while reset is held
  assign inst_sram_en   = (state_q == S_REQ) && !reset && !misal_c;
  assign inst_sram_addr = pc_q;
  assign out_valid      = out_valid_q;
  assign out_pc         = ir_pc_q;
  assign out_inst       = ir_q;

  // Next-state logic; redirect takes priority over every normal transition
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    adef_d  = adef_q;
    case (state_q)
      S_REQ: begin
        adef_d = 1'b0;
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else begin
          ir_d    = misal_c ? 32'h0 : inst_sram_rdata;
          ir_pc_d = pc_q;
          adef_d  = misal_c;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          adef_d  = 1'b0;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 32'(PC_STEP);
          adef_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      default: begin
        adef_d  = 1'b0;
        state_d = S_REQ;
      end
    endcase
    out_valid_d = (state_d == S_HOLD);
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      ir_pc_q     <= 32'h0;
      out_valid_q <= 1'b0;
      adef_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      out_valid_q <= out_valid_d;
      adef_q      <= adef_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Multi-cycle instruction fetch stage for the LoongArch core. It owns the architectural PC and drives the synchronous instruction SRAM, which has a 1-cycle read latency. It latches the returned word into an instruction register and presents {pc, inst} to the downstream decode/execute FSM over a valid/ready handshake. It accepts branch/jump redirects from the execute stage at any time.

Parameters:
RESET_PC, 32'h1c000000, PC value of the first fetch after reset.
PC_STEP, 4, PC increment after each consumed instruction.

Ports:
clk              in   1   clock, all state updates on posedge.
reset            in   1   synchronous, active-high reset.
inst_sram_en     out  1   read request strobe to instruction SRAM.
inst_sram_addr   out  32  read address; equals pc while inst_sram_en=1.
inst_sram_rdata  in   32  read data, valid the cycle after the request.
out_valid        out  1   {out_pc, out_inst} hold a fetched instruction.
out_ready        in   1   consumer accepts the instruction this cycle.
out_pc           out  32  PC of the presented instruction.
out_inst         out  32  fetched instruction word.
redirect_valid   in   1   branch taken; restart fetch at redirect_pc.
redirect_pc      in   32  redirect target.
fetch_adef       out  1   present only with FETCH_ADEF_EN; see Optional Feature.

Behaviour:
- Reset (synchronous, active-high):
  - state=S_REQ, pc=RESET_PC, out_valid=0, out_pc=0, out_inst=0, inst_sram_en=0.
  - inst_sram_en is gated low while reset=1.
- Registers:
  - pc (32): next fetch address.
  - ir_pc, ir (32 each): drive out_pc and out_inst.
  - State: 2-bit encoding.
- inst_sram_addr = pc in every state. It is meaningful only when inst_sram_en=1.
- S_REQ:
  - inst_sram_en=1, out_valid=0.
  - Next state: S_RESP.
- S_RESP:
  - inst_sram_en=0.
  - ir <= inst_sram_rdata, ir_pc <= pc.
  - Next state: S_HOLD.
- S_HOLD:
  - out_valid=1.
  - ir and ir_pc are held stable until the handshake completes.
  - If out_ready=1: pc <= pc + PC_STEP (32-bit wrap), next state S_REQ.
  - If out_ready=0: remain in S_HOLD.
- Latency and throughput:
  - Request in cycle t; out_valid=1 from cycle t+2.
  - With out_ready tied high, one instruction every 3 cycles.
  - out_valid is a registered output (equals state==S_HOLD). It never depends combinationally on out_ready.
- Redirect (redirect_valid=1 sampled on posedge) has priority over every transition above:
  - In S_REQ: pc <= redirect_pc, remain in S_REQ. The in-flight request result is never used.
  - In S_RESP: the returning rdata is discarded (ir is not updated). pc <= redirect_pc, next state S_REQ.
  - In S_HOLD with out_ready=1: the handshake counts as completed. pc <= redirect_pc (not pc+4), next state S_REQ.
  - In S_HOLD with out_ready=0: the held instruction is dropped. out_valid=0 next cycle, pc <= redirect_pc, next state S_REQ.
- Reset mid-operation overrides redirect and the handshake. Any held or in-flight instruction is lost.
- Illegal state encoding: recovers to S_REQ on the next cycle.

Optional Feature:
Macro: FETCH_ADEF_EN.
- Defined:
  - Port fetch_adef exists.
  - In S_REQ, if pc[1:0]!=0: inst_sram_en stays 0 and the FSM skips the SRAM access.
  - It goes S_REQ -> S_RESP -> S_HOLD with ir=32'h0 and fetch_adef=1 while in S_HOLD.
  - fetch_adef clears when the handshake completes, on redirect, or on reset (reset value 0).
- Not defined:
  - No port and no alignment check.
  - pc[1:0] are driven unchanged onto inst_sram_addr.

Test Plan:
1. Reset 3 cycles, then release with out_ready=1 and rdata = addr^32'hA5A5A5A5. First en=1 with addr 0x1c000000 on the first cycle after release. out_valid=1 two cycles later with out_pc=0x1c000000, out_inst=0xB9A5A5A5. Next request at 0x1c000004 three cycles after the first.
2. Backpressure: hold out_ready=0 for 5 cycles in S_HOLD. out_valid, out_pc and out_inst stay stable. No en pulses. pc advances by exactly 4 after out_ready rises.
3. Redirect in S_RESP to 0x1c000100. The returning word never appears on out_inst. Next en=1 with addr 0x1c000100. The next out_pc is 0x1c000100.
4. Redirect to 0x1c000200 in the same cycle as out_ready=1 in S_HOLD. The instruction is consumed once. The next fetch address is 0x1c000200, not pc+4.
5. Assert reset while in S_HOLD. out_valid=0 next cycle. The next fetch address is 0x1c000000.
6. With FETCH_ADEF_EN defined, redirect to 0x1c000102. No en pulse for that PC. out_valid=1 with fetch_adef=1, out_inst=0, out_pc=0x1c000102. A further redirect to 0x1c000000 clears fetch_adef.
